// File: rtl/cpu_pll_reset_seq_pkg.sv
// cpu_pll_pkg
//   Shared types and default parameter values for the CPU PLL reset
//   sequencer (cpu_pll_reset_seq) and its bench.
//   Contents:
//     pll_seq_state_t     sequencer state encoding
//     DEF_*               default values of the sequencer parameters
//     max3()              largest of three cycle counts, used to size
//                         the shared phase counter
package cpu_pll_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_seq_state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cpu_pll_reset_seq_sync_2ff.sv
// sync_2ff
//   Generic two-flop synchroniser with synchronous active-high reset.
//   The flops reset to 0, so a synchronised "good" indication is never
//   seen until two clean samples have been taken after reset.
//   Ports:
//     clk   in          destination clock
//     rst   in          synchronous reset, active high
//     d     in  [W-1:0] asynchronous input
//     q     out [W-1:0] synchronised output, two cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpu_pll_reset_seq.sv
// cpu_pll_reset_seq
//   Brings up the CPU clock PLL from the free-running board clock:
//   pulses the PLL reset, waits for lock, qualifies the lock as stable
//   and only then releases the CPU system reset. Loss of lock while
//   running drops the system reset again and restarts the PLL. A lock
//   timeout retries a bounded number of times before latching failure.
//
//   Ports:
//     refclk         in       board clock, the only clock
//     rst            in       synchronous reset, active high
//     pll_locked     in       PLL lock, asynchronous to refclk
//     pll_rst        out      PLL reset, active high
//     cpu_rst        out      CPU system reset, active high
//     ready          out      high only while running
//     fail           out      sticky failure flag, cleared only by rst
//     retry_cnt      out [8]  retries since rst or the last RUN, saturating
//     lock_loss_cnt  out [8]  (CPU_PLL_LOCK_LOSS_CNT_EN only) RUN->PLL_RST
//                             transitions since rst, saturating
//
//   Build option: define CPU_PLL_LOCK_LOSS_CNT_EN to add lock_loss_cnt.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   PLL_RST   | PLL held in reset for PLL_RST_CYCLES
//   WAIT_LOCK | PLL released, waiting for lock (bounded by timeout)
//   STABLE    | lock seen, must hold for LOCK_STABLE_CYCLES
//   RUN       | CPU released; any lock loss restarts the PLL
//   FAIL      | retries exhausted; PLL and CPU held in reset
module cpu_pll_reset_seq
    import cpu_pll_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       cpu_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt
`ifdef CPU_PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    // One extra bit over the largest terminal count so the saturating
    // counter can never alias a terminal value.
    localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    pll_seq_state_t   state;
    pll_seq_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       retry_nxt;
    logic             lock_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        case (state)
            PLL_RST: begin
                if (cnt == PLL_RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as a lock.
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt = PLL_RST;
                        if (retry_cnt != 8'hFF) retry_nxt = retry_cnt + 8'd1;
                    end
                end
            end
            STABLE: begin
                if (!lock_s)                  state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) state_nxt = PLL_RST;
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = PLL_RST;
            end
        endcase
        if (state_nxt == RUN) retry_nxt = '0;
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            cpu_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)  cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            pll_rst   <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
            cpu_rst   <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            fail      <= (state_nxt == FAIL);
            retry_cnt <= retry_nxt;
        end
    end

`ifdef CPU_PLL_LOCK_LOSS_CNT_EN
    // Survives retries and RUN; only the external reset clears it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (state == RUN && state_nxt == PLL_RST && lock_loss_cnt != 8'hFF) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_pll_reset_seq.sv
// tb_cpu_pll_reset_seq
//   Bench for cpu_pll_reset_seq with small cycle parameters. A reference
//   model tracks the sequencer as a phase plus time spent in that phase;
//   every cycle all outputs are compared against it. Directed scenarios
//   add explicit timing checks, then a randomized lock pattern runs.
module tb_cpu_pll_reset_seq;

    localparam int P_RST  = 4;
    localparam int P_STAB = 8;
    localparam int P_TO   = 32;
    localparam int P_MAXR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       cpu_rst;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
`ifdef CPU_PLL_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_pll_reset_seq #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .MAX_RETRIES         (P_MAXR)
    ) dut (
        .refclk        (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .cpu_rst       (cpu_rst),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt)
`ifdef CPU_PLL_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {PH_PULSE, PH_WAIT, PH_QUAL, PH_RUN, PH_DEAD} phase_t;
    phase_t m_ph = PH_PULSE;
    int     m_t = 0;            // edges already spent in m_ph
    int     m_retries = 0;
    int     m_losses = 0;
    bit     m_hist[2] = '{0, 0}; // pll_locked samples: [0] newest, [1] older

    task automatic model_step(input bit r, input bit lk);
        bit     seen;
        phase_t nxt;
        if (r) begin
            m_ph = PH_PULSE; m_t = 0; m_retries = 0; m_losses = 0;
            m_hist[0] = 0; m_hist[1] = 0;
            return;
        end
        seen = m_hist[1];       // lock as seen two samples late
        m_hist[1] = m_hist[0];
        m_hist[0] = lk;
        nxt = m_ph;
        case (m_ph)
            PH_PULSE: if (m_t + 1 == P_RST) nxt = PH_WAIT;
            PH_WAIT: begin
                if (seen) nxt = PH_QUAL;
                else if (m_t + 1 == P_TO) begin
                    if (m_retries == P_MAXR) nxt = PH_DEAD;
                    else begin
                        nxt = PH_PULSE;
                        m_retries++;
                    end
                end
            end
            PH_QUAL: begin
                if (!seen) nxt = PH_WAIT;
                else if (m_t + 1 == P_STAB) nxt = PH_RUN;
            end
            PH_RUN: begin
                if (!seen) begin
                    nxt = PH_PULSE;
                    if (m_losses < 255) m_losses++;
                end
            end
            default: nxt = m_ph;
        endcase
        if (nxt == PH_RUN) m_retries = 0;
        m_t = (nxt == m_ph) ? m_t + 1 : 0;
        m_ph = nxt;
    endtask

    task automatic cycle(input bit r, input bit lk);
        @(negedge clk);
        rst = r;
        pll_locked = lk;
        @(posedge clk);
        model_step(r, lk);
        #1;
        chk_eq("pll_rst",   32'(pll_rst), 32'(m_ph == PH_PULSE || m_ph == PH_DEAD));
        chk_eq("cpu_rst",   32'(cpu_rst), 32'(m_ph != PH_RUN));
        chk_eq("ready",     32'(ready),   32'(m_ph == PH_RUN));
        chk_eq("fail",      32'(fail),    32'(m_ph == PH_DEAD));
        chk_eq("retry_cnt", 32'(retry_cnt), 32'(m_retries));
`ifdef CPU_PLL_LOCK_LOSS_CNT_EN
        chk_eq("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_losses));
`endif
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    initial begin
        int pll_fall, rdy_at, falls, highs, seg, lvl;
        bit prev;

        // 1: basic bring-up, lock 10 cycles after release
        do_reset(3);
        chk_eq("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk_eq("rst_ready",   32'(ready),   32'd0);
        pll_fall = 0; rdy_at = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, i >= 10);
            if (pll_fall == 0 && !pll_rst) pll_fall = i;
            if (rdy_at == 0 && !cpu_rst) begin rdy_at = i; break; end
        end
        chk_eq("s1_pll_rst_len", 32'(pll_fall), 32'(P_RST));
        chk_eq("s1_release_at",  32'(rdy_at),   32'(10 + 2 + P_STAB));
        chk_eq("s1_ready",       32'(ready),    32'd1);

        // 2: lock never arrives -> three pulses, then FAIL
        do_reset(2);
        falls = 0; prev = 1'b1;
        for (int i = 1; i <= 3 * (P_RST + P_TO) + 10; i++) begin
            cycle(1'b0, 1'b0);
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
        end
        chk_eq("s2_pulses",    32'(falls),     32'd3);
        chk_eq("s2_fail",      32'(fail),      32'd1);
        chk_eq("s2_pll_rst",   32'(pll_rst),   32'd1);
        chk_eq("s2_retry_cnt", 32'(retry_cnt), 32'd2);

        // 5b: rst out of FAIL clears fail and restarts
        cycle(1'b1, 1'b0);
        chk_eq("s5_fail_clr",  32'(fail),      32'd0);
        chk_eq("s5_retry_clr", 32'(retry_cnt), 32'd0);
        rdy_at = 0;
        for (int i = 1; i <= 60; i++) begin
            cycle(1'b0, 1'b1);
            if (ready) begin rdy_at = i; break; end
        end
        chk_eq("s5_restart_ready_at", 32'(rdy_at), 32'(P_RST + 1 + P_STAB));

        // 3: one-cycle lock drop while running
        falls = 0; highs = 0; rdy_at = 0;
        cycle(1'b0, 1'b0);
        for (int i = 1; i <= 60; i++) begin
            cycle(1'b0, 1'b1);
            if (falls == 0 && !ready) falls = i;
            if (pll_rst) highs++;
            if (falls != 0 && ready) begin rdy_at = i; break; end
        end
        chk_eq("s3_drop_latency", 32'(falls), 32'd2);
        chk_eq("s3_pll_rst_len",  32'(highs), 32'(P_RST));
        chk_eq("s3_relocked",     32'(ready), 32'd1);
`ifdef CPU_PLL_LOCK_LOSS_CNT_EN
        chk_eq("s3_lock_loss", 32'(lock_loss_cnt), 32'd1);
`endif

        // 4: glitch while qualifying (seen at qualification count 5)
        do_reset(2);
        rdy_at = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, i != 9);
            if (rdy_at == 0 && ready) rdy_at = i;
        end
        // clean run releases at edge 13; the glitch restarts qualification at 12
        chk_eq("s4_release_at", 32'(rdy_at), 32'd20);

        // 5a: rst while qualifying, then clean restart
        do_reset(2);
        for (int i = 1; i <= 7; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk_eq("s5_stable_pll_rst", 32'(pll_rst), 32'd1);
        chk_eq("s5_stable_cpu_rst", 32'(cpu_rst), 32'd1);
        rdy_at = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b1);
            if (rdy_at == 0 && ready) rdy_at = i;
        end
        chk_eq("s5_clean_release_at", 32'(rdy_at), 32'd13);

        // 6: lock seen exactly on the timeout cycle, and one cycle late
        do_reset(2);
        rdy_at = 0;
        for (int i = 1; i <= 60; i++) begin
            cycle(1'b0, i >= 34);
            if (i == 36) chk_eq("s6_no_retry", 32'(retry_cnt), 32'd0);
            if (rdy_at == 0 && ready) rdy_at = i;
        end
        chk_eq("s6_release_at", 32'(rdy_at), 32'd44);
        do_reset(2);
        for (int i = 1; i <= 36; i++) cycle(1'b0, i >= 35);
        chk_eq("s6_late_retry", 32'(retry_cnt), 32'd1);

        // randomized lock pattern with occasional resets
        do_reset(2);
        lvl = 1;
        for (int s = 0; s < 120; s++) begin
            if (lvl != 0) seg = $urandom_range(40, 1);
            else if ($urandom_range(3, 0) == 0) seg = $urandom_range(130, 30);
            else seg = $urandom_range(6, 1);
            for (int k = 0; k < seg; k++)
                cycle($urandom_range(299, 0) == 0, lvl != 0);
            lvl = 1 - lvl;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
